// File: rtl/mips_pkg.sv
// Shared widths and the buffered write-back entry for the MIPS write-back path.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending MDU write-backs with per-entry WAW squash.
// Dead entries ahead of the oldest live one are discarded every cycle.
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  input  logic                        squash_en,
  input  logic [REG_W-1:0]            squash_rd,
  output logic                        full,
  output wb_entry_t                   head,
  output logic [PTR_W-1:0]            head_idx,
  output logic [DEPTH-1:0]            live,
  output logic [DEPTH-1:0][REG_W-1:0] live_rd
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] skip;
  logic [CNT_W-1:0] advance;
  logic             head_found;

  assign full = (count == CNT_W'(DEPTH));

  // Oldest live entry; everything before it (or all of it, if none) is dead.
  always_comb begin
    head_found = 1'b0;
    head_idx   = rd_ptr;
    skip       = count;
    for (int k = 0; k < DEPTH; k++) begin
      if (!head_found && (CNT_W'(k) < count) && mem[rd_ptr + PTR_W'(k)].valid) begin
        head_found = 1'b1;
        head_idx   = rd_ptr + PTR_W'(k);
        skip       = CNT_W'(k);
      end
    end
    advance    = skip + CNT_W'(pop && head_found);
    head       = mem[head_idx];
    head.valid = head_found;
  end

  always_comb begin
    live    = '0;
    live_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i]    = mem[i].valid && ({1'b0, PTR_W'(i) - rd_ptr} < count);
      live_rd[i] = mem[i].rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (squash_en) begin
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].rd == squash_rd) mem[i].valid <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr + advance[PTR_W-1:0];
      count  <= count - advance + CNT_W'(push);
    end
  end

endmodule

// File: rtl/mips_writeback_unit.sv
// Register-file write port arbiter: ALU results preempt buffered MDU results,
// which in turn preempt a direct MDU write.
module mips_writeback_unit
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              writeBack,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] din,
  output logic [31:0]       busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                        alu_busy;
  logic                        mdu_fire;
  logic                        mdu_live;
  logic                        pop;
  logic                        direct;
  logic                        push;
  logic                        full;
  wb_entry_t                   head;
  wb_entry_t                   push_entry;
  logic [PTR_W-1:0]            head_idx;
  logic [DEPTH-1:0]            live;
  logic [DEPTH-1:0][REG_W-1:0] live_rd;

  assign alu_busy  = alu_valid && (alu_rd != REG_ZERO);
  assign mdu_ready = !full;
  assign mdu_fire  = mdu_valid && mdu_ready;
  // A same-cycle MDU result to the ALU's target is older than the ALU write.
  assign mdu_live  = mdu_fire && (mdu_rd != REG_ZERO) && !(alu_busy && (mdu_rd == alu_rd));
  assign pop       = !alu_busy && head.valid;
  assign direct    = !alu_busy && !head.valid && mdu_live;
  assign push      = mdu_live && !direct;

  assign push_entry = '{valid: 1'b1, rd: mdu_rd, data: mdu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (alu_busy),
    .squash_rd  (alu_rd),
    .full       (full),
    .head       (head),
    .head_idx   (head_idx),
    .live       (live),
    .live_rd    (live_rd)
  );

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i] && !(pop && (PTR_W'(i) == head_idx))) busy_mask[live_rd[i]] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      writeBack <= 1'b0;
      rd        <= '0;
      din       <= '0;
    end else begin
      writeBack <= alu_busy || pop || direct;
      if (alu_busy) begin
        rd  <= alu_rd;
        din <= alu_data;
      end else if (pop) begin
        rd  <= head.rd;
        din <= head.data;
      end else if (direct) begin
        rd  <= mdu_rd;
        din <= mdu_data;
      end
    end
  end

endmodule
